// File: rtl/vram_upload.sv
// Read-back responder for the HPS ioctl upload path: serves ioctl_rd strobes from
// the video RAM read port, stalls the HPS while busy, and tallies bytes and checksum.
module vram_upload #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RAM_LAT = 1,
    parameter int unsigned SIZE    = 16000
) (
    input  logic              pixel_clock,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [ADDR_W-1:0] ioctl_addr,
    output logic [DATA_W-1:0] ioctl_din,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_q,
    input  logic              ram_busy,
    output logic              progress,
    output logic              upload_done,
    output logic [ADDR_W:0]   byte_count,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_LAT,
        S_CAP
    } state_t;

    localparam logic [ADDR_W:0] LP_SIZE     = (ADDR_W+1)'(SIZE);
    // The grant cycle counts as the first latency cycle, so LAT holds RAM_LAT-1 cycles
    // and CAP samples ram_q exactly RAM_LAT cycles after ram_rd.
    localparam logic [1:0]      LP_LAT_LOAD = 2'(RAM_LAT - 1);

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_lat;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_zero;
    logic                r_wait;
    logic [DATA_W-1:0]   r_din;
    logic                r_prog;
    logic                r_done;
    logic [ADDR_W:0]     r_count;
    logic [DATA_W-1:0]   r_sum;

    logic                w_oor;
    logic                w_accept;
    logic                w_grant;
    logic                w_capture;
    logic                w_rise;
    logic                w_fall;
    logic [DATA_W-1:0]   w_data;

    assign w_oor     = ({1'b0, ioctl_addr} >= LP_SIZE);
    assign w_rise    = ioctl_upload & ~r_prog;
    assign w_fall    = ~ioctl_upload & r_prog;
    assign w_capture = (r_state == S_CAP) & ioctl_upload;
    assign w_data    = r_zero ? '0 : ram_q;

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_grant  = 1'b0;
        if (!ioctl_upload) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ioctl_rd) begin
                        w_accept = 1'b1;
                        w_next   = w_oor ? S_CAP : S_ARB;
                    end
                end
                S_ARB: begin
                    if (!ram_busy) begin
                        w_grant = 1'b1;
                        w_next  = (RAM_LAT > 1) ? S_LAT : S_CAP;
                    end
                end
                S_LAT: begin
                    if (r_lat == 2'd1) begin
                        w_next = S_CAP;
                    end
                end
                S_CAP: begin
                    w_next = S_IDLE;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lat   <= '0;
            r_addr  <= '0;
            r_zero  <= 1'b0;
            r_wait  <= 1'b0;
            r_din   <= '0;
            r_prog  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
            r_sum   <= '0;
        end else begin
            r_prog <= ioctl_upload;
            r_done <= w_fall;

            if (w_accept) begin
                r_addr <= ioctl_addr;
                r_zero <= w_oor;
                r_wait <= 1'b1;
            end

            if (!ioctl_upload) begin
                r_lat  <= '0;
                r_wait <= 1'b0;
            end else if (w_grant) begin
                r_lat <= LP_LAT_LOAD;
            end else if (r_state == S_LAT) begin
                r_lat <= r_lat - 2'd1;
            end

            // A capture cannot coincide with a session start: CAP needs upload already high.
            if (w_rise) begin
                r_count <= '0;
                r_sum   <= '0;
            end else if (w_capture) begin
                r_din  <= w_data;
                r_wait <= 1'b0;
                r_sum  <= r_sum + w_data;
                if (r_count != '1) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign ioctl_din   = r_din;
    assign ioctl_wait  = r_wait;
    assign ram_addr    = r_addr;
    assign ram_rd      = w_grant;
    assign progress    = r_prog;
    assign upload_done = r_done;
    assign byte_count  = r_count;
    assign checksum    = r_sum;

endmodule

// File: tb/tb_vram_upload.sv
// Directed bench for vram_upload: RAM model with one-cycle latency, expected read
// data queued at issue and compared at completion, plus session and reset checks.
module tb_vram_upload;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic        ioctl_rd = 1'b0;
    logic [13:0] ioctl_addr = '0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [13:0] ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_q = 8'h00;
    logic        ram_busy = 1'b0;
    logic        progress;
    logic        upload_done;
    logic [14:0] byte_count;
    logic [7:0]  checksum;

    logic [7:0]  mem [0:16383];
    logic [7:0]  sb [$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          m_cnt = 0;
    logic [7:0]  m_sum = 8'h00;

    always #5 clk = ~clk;

    vram_upload #(
        .ADDR_W (14),
        .DATA_W (8),
        .RAM_LAT(1),
        .SIZE   (16000)
    ) dut (
        .pixel_clock (clk),
        .reset_n     (reset_n),
        .ioctl_upload(ioctl_upload),
        .ioctl_rd    (ioctl_rd),
        .ioctl_addr  (ioctl_addr),
        .ioctl_din   (ioctl_din),
        .ioctl_wait  (ioctl_wait),
        .ram_addr    (ram_addr),
        .ram_rd      (ram_rd),
        .ram_q       (ram_q),
        .ram_busy    (ram_busy),
        .progress    (progress),
        .upload_done (upload_done),
        .byte_count  (byte_count),
        .checksum    (checksum)
    );

    // Data is valid only for the cycle after the read; otherwise a junk pattern.
    always @(posedge clk) ram_q <= ram_rd ? mem[ram_addr] : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_din"},   32'(ioctl_din),   32'h0);
        chk({tag, "_wait"},  32'(ioctl_wait),  32'h0);
        chk({tag, "_raddr"}, 32'(ram_addr),    32'h0);
        chk({tag, "_rd"},    32'(ram_rd),      32'h0);
        chk({tag, "_prog"},  32'(progress),    32'h0);
        chk({tag, "_done"},  32'(upload_done), 32'h0);
        chk({tag, "_cnt"},   32'(byte_count),  32'h0);
        chk({tag, "_sum"},   32'(checksum),    32'h0);
    endtask

    task automatic read_txn(input logic [13:0] a, input int busy_n, input bit rd2, input bit with_rise);
        logic [7:0] e;
        int done_at;
        int rd_at;
        int rd_cnt;
        bit oor;
        oor = (a >= 14'd16000);
        e = oor ? 8'h00 : mem[a];
        sb.push_back(e);
        if (with_rise) begin
            m_cnt = 0;
            m_sum = 8'h00;
        end
        m_cnt++;
        m_sum = m_sum + e;
        done_at = -1;
        rd_at = -1;
        rd_cnt = 0;
        @(posedge clk); #1;
        ioctl_addr = a;
        ioctl_rd = 1'b1;
        ram_busy = 1'b0;
        if (with_rise) ioctl_upload = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            ioctl_rd = (k == 1) && rd2;
            ioctl_addr = ((k == 1) && rd2) ? 14'd7 : a;
            ram_busy = (k <= busy_n);
            @(negedge clk);
            if (ram_rd) begin
                rd_cnt++;
                if (rd_at < 0) rd_at = k;
            end
            if (!ioctl_wait) begin
                done_at = k;
                break;
            end
        end
        ram_busy = 1'b0;
        chk("ram_addr", 32'(ram_addr), 32'(a));
        chk("latency", 32'(done_at), oor ? 32'd2 : 32'(3 + busy_n));
        chk("ram_rd_cycle", 32'(rd_at), oor ? 32'hFFFF_FFFF : 32'(1 + busy_n));
        chk("ram_rd_count", 32'(rd_cnt), oor ? 32'd0 : 32'd1);
        if (sb.size() > 0) chk("din", 32'(ioctl_din), 32'(sb.pop_front()));
        chk("byte_count", 32'(byte_count), 32'(m_cnt));
        chk("checksum", 32'(checksum), 32'(m_sum));
    endtask

    task automatic end_session();
        @(posedge clk); #1;
        ioctl_upload = 1'b0;
        @(negedge clk);
        chk("done_early", 32'(upload_done), 32'h0);
        @(negedge clk);
        chk("done_pulse", 32'(upload_done), 32'h1);
        chk("wait_idle", 32'(ioctl_wait), 32'h0);
        @(negedge clk);
        chk("done_single", 32'(upload_done), 32'h0);
        chk("cnt_held", 32'(byte_count), 32'(m_cnt));
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'(i * 37 + 11);
        mem[5]   = 8'hA7;
        mem[256] = 8'h10;
        mem[257] = 8'h20;
        mem[258] = 8'hF5;

        #12;
        chk_zero("reset");

        @(posedge clk); #1;
        reset_n = 1'b1;
        ioctl_upload = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("progress", 32'(progress), 32'h1);

        read_txn(14'd5, 0, 1'b0, 1'b0);
        read_txn(14'd9, 4, 1'b0, 1'b0);
        read_txn(14'd16000, 0, 1'b0, 1'b0);
        read_txn(14'd16383, 0, 1'b0, 1'b0);
        read_txn(14'd5, 2, 1'b1, 1'b0);
        end_session();

        // Session opened in the same cycle as the first read.
        read_txn(14'd256, 0, 1'b0, 1'b1);
        read_txn(14'd257, 1, 1'b0, 1'b0);
        read_txn(14'd258, 0, 1'b0, 1'b0);
        chk("sess_cnt", 32'(byte_count), 32'd3);
        chk("sess_sum", 32'(checksum), 32'h25);
        end_session();

        // Abort while the RAM read is in flight.
        read_txn(14'd40, 0, 1'b0, 1'b1);
        @(posedge clk); #1;
        ioctl_addr = 14'd300;
        ioctl_rd = 1'b1;
        @(posedge clk); #1;
        ioctl_rd = 1'b0;
        @(posedge clk); #1;
        ioctl_upload = 1'b0;
        @(negedge clk);
        chk("abort_rd", 32'(ram_rd), 32'h0);
        chk("abort_wait_before", 32'(ioctl_wait), 32'h1);
        @(negedge clk);
        chk("abort_wait", 32'(ioctl_wait), 32'h0);
        chk("abort_done", 32'(upload_done), 32'h1);
        chk("abort_cnt", 32'(byte_count), 32'd1);
        chk("abort_din", 32'(ioctl_din), 32'(mem[40]));
        @(negedge clk);
        chk("abort_done_single", 32'(upload_done), 32'h0);

        // Asynchronous reset while stalled in arbitration.
        @(posedge clk); #1;
        ioctl_upload = 1'b1;
        @(posedge clk); #1;
        ioctl_addr = 14'd20;
        ioctl_rd = 1'b1;
        ram_busy = 1'b1;
        @(posedge clk); #1;
        ioctl_rd = 1'b0;
        @(negedge clk);
        chk("arb_wait", 32'(ioctl_wait), 32'h1);
        chk("arb_rd", 32'(ram_rd), 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        ram_busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_reset_done", 32'(upload_done), 32'h0);
        end
        m_cnt = 0;
        m_sum = 8'h00;
        read_txn(14'd5, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
